// File: rtl/csr_unit_if.sv
// Request/response bundle between main control and the M-mode CSR/trap unit.
// Latency: pure wiring, no storage.
// Backpressure: none; the CSR unit consumes every request in the cycle it is presented.
interface csr_unit_if;
    logic        i_csr_en;
    logic [31:0] i_inst;
    logic [31:0] i_wd;
    logic [31:0] i_pc;
    logic [31:0] i_badaddr;
    logic        i_retire;
    logic        i_ex_ill;
    logic        i_ex_inst_addr;
    logic        i_ex_ld_addr;
    logic        i_ex_st_addr;
    logic        i_irq_sw;
    logic        i_irq_timer;
    logic        i_irq_ext;
    logic [31:0] o_rd;
    logic        o_csr_ill;
    logic        o_trap;
    logic        o_eret;
    logic [31:0] o_tvec;
    logic [31:0] o_epc;
    logic [31:0] o_cause;

    // Main control drives requests and observes trap/CSR results.
    modport master (
        output i_csr_en, i_inst, i_wd, i_pc, i_badaddr, i_retire,
        output i_ex_ill, i_ex_inst_addr, i_ex_ld_addr, i_ex_st_addr,
        output i_irq_sw, i_irq_timer, i_irq_ext,
        input  o_rd, o_csr_ill, o_trap, o_eret, o_tvec, o_epc, o_cause
    );

    // The CSR unit sees the mirror image.
    modport slave (
        input  i_csr_en, i_inst, i_wd, i_pc, i_badaddr, i_retire,
        input  i_ex_ill, i_ex_inst_addr, i_ex_ld_addr, i_ex_st_addr,
        input  i_irq_sw, i_irq_timer, i_irq_ext,
        output o_rd, o_csr_ill, o_trap, o_eret, o_tvec, o_epc, o_cause
    );
endinterface

// File: rtl/csr_unit.sv
// Machine-mode CSR file and trap controller: CSR access, exception/interrupt entry, MRET, 64-bit counters.
// Latency: read data, trap decision, vector and cause are combinational; state updates on the i_clk rise.
// Backpressure: none; a request presented with i_csr_en completes in the same cycle.
module csr_unit #(
    parameter logic [31:0] HART_ID   = 32'h0,
    parameter bit          VECTORED  = 1'b1,
    parameter bit          CNT_EN    = 1'b1,
    parameter logic [31:0] MTVEC_RST = 32'h0
) (
    input  logic      i_clk,
    input  logic      i_rst,
    csr_unit_if.slave bus
);
    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MIE       = 12'h304;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MTVAL     = 12'h343;
    localparam logic [11:0] A_MIP       = 12'h344;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_MHARTID   = 12'hF14;
    localparam logic [31:0] MISA_VAL    = 32'h4000_0100;  // MXL=32, I extension

    // Architectural state
    logic        st_mie, st_mpie;
    logic [2:0]  mie_en;          // {MEIE, MTIE, MSIE}
    logic [29:0] mtvec_base;
    logic        mtvec_mode;
    logic [31:0] mscratch, mcause, mtval;
    logic [29:0] mepc_w;
    logic [63:0] mcycle, minstret;

    // Decode
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [4:0]  src_idx;
    logic        sys_vld, priv_op, is_ecall, is_ebreak, is_mret;
    logic        csr_op, csr_wr_req, csr_ill, wr_en;
    logic [31:0] rd_dat, src_dat, wr_dat;
    logic        rd_impl, rd_ro;
    logic        exc, irq, trap;
    logic [3:0]  exc_code, irq_code;
    logic [31:0] exc_tval, trap_cause;
    logic [2:0]  irq_lines, irq_pend;

    assign f3       = bus.i_inst[14:12];
    assign addr     = bus.i_inst[31:20];
    assign src_idx  = bus.i_inst[19:15];
    assign sys_vld  = bus.i_csr_en && (bus.i_inst[6:0] == 7'b1110011);
    // ECALL/EBREAK/MRET share f3=0 with rd=rs1=0; the immediate tells them apart
    assign priv_op  = sys_vld && (f3 == 3'b000) && (bus.i_inst[19:7] == 13'd0);
    assign is_ecall  = priv_op && (addr == 12'h000);
    assign is_ebreak = priv_op && (addr == 12'h001);
    assign is_mret   = priv_op && (addr == 12'h302);
    assign csr_op    = sys_vld && (f3[1:0] != 2'b00);
    // Set/clear with a zero source register index or zero immediate leaves state alone
    assign csr_wr_req = csr_op && ((f3[1:0] == 2'b01) || (src_idx != 5'd0));
    assign csr_ill    = csr_op && (!rd_impl || (rd_ro && csr_wr_req));
    assign wr_en      = csr_wr_req && !csr_ill && !trap;
    assign irq_lines  = {bus.i_irq_ext, bus.i_irq_timer, bus.i_irq_sw};

    // Combinational CSR read mux; unimplemented addresses read zero
    always_comb begin
        rd_dat  = 32'd0;
        rd_impl = 1'b1;
        rd_ro   = 1'b0;
        case (addr)
            A_MSTATUS:   rd_dat = {19'd0, 2'b11, 3'd0, st_mpie, 3'd0, st_mie, 3'd0};
            A_MISA:      begin rd_dat = MISA_VAL; rd_ro = 1'b1; end
            A_MIE:       rd_dat = {20'd0, mie_en[2], 3'd0, mie_en[1], 3'd0, mie_en[0], 3'd0};
            A_MTVEC:     rd_dat = {mtvec_base, 1'b0, mtvec_mode};
            A_MSCRATCH:  rd_dat = mscratch;
            A_MEPC:      rd_dat = {mepc_w, 2'b00};
            A_MCAUSE:    rd_dat = mcause;
            A_MTVAL:     rd_dat = mtval;
            A_MIP:       begin rd_dat = {20'd0, irq_lines[2], 3'd0, irq_lines[1], 3'd0, irq_lines[0], 3'd0}; rd_ro = 1'b1; end
            A_MCYCLE:    rd_dat = mcycle[31:0];
            A_MCYCLEH:   rd_dat = mcycle[63:32];
            A_MINSTRET:  rd_dat = minstret[31:0];
            A_MINSTRETH: rd_dat = minstret[63:32];
            A_MHARTID:   begin rd_dat = HART_ID; rd_ro = 1'b1; end
            default:     rd_impl = 1'b0;
        endcase
    end

    // Write value for RW/RS/RC, register or zero-extended immediate source
    always_comb begin
        src_dat = f3[2] ? {27'd0, src_idx} : bus.i_wd;
        wr_dat  = rd_dat;
        case (f3[1:0])
            2'b01:   wr_dat = src_dat;
            2'b10:   wr_dat = rd_dat | src_dat;
            2'b11:   wr_dat = rd_dat & ~src_dat;
            default: wr_dat = rd_dat;
        endcase
    end

    // Fixed exception priority and the matching trap value
    always_comb begin
        exc      = 1'b1;
        exc_code = 4'd0;
        exc_tval = 32'd0;
        if (bus.i_ex_inst_addr) begin
            exc_code = 4'd0;  exc_tval = bus.i_badaddr;
        end else if (bus.i_ex_ill) begin
            exc_code = 4'd2;  exc_tval = bus.i_inst;
        end else if (is_ebreak) begin
            exc_code = 4'd3;  exc_tval = bus.i_pc;
        end else if (is_ecall) begin
            exc_code = 4'd11; exc_tval = 32'd0;
        end else if (bus.i_ex_ld_addr) begin
            exc_code = 4'd4;  exc_tval = bus.i_badaddr;
        end else if (bus.i_ex_st_addr) begin
            exc_code = 4'd6;  exc_tval = bus.i_badaddr;
        end else begin
            exc = 1'b0;
        end
    end

    // Interrupts only when no exception is pending; MEI beats MSI beats MTI
    always_comb begin
        irq_pend = mie_en & irq_lines;
        irq      = !exc && st_mie && (irq_pend != 3'd0);
        irq_code = 4'd7;
        if (irq_pend[2])      irq_code = 4'd11;
        else if (irq_pend[0]) irq_code = 4'd3;
    end

    assign trap          = exc || irq;
    assign trap_cause    = exc ? {28'd0, exc_code} : {1'b1, 27'd0, irq_code};
    assign bus.o_rd      = rd_dat;
    assign bus.o_csr_ill = csr_ill;
    assign bus.o_trap    = trap;
    assign bus.o_eret    = is_mret && !trap;
    assign bus.o_epc     = {mepc_w, 2'b00};
    assign bus.o_cause   = trap ? trap_cause : 32'd0;
    assign bus.o_tvec    = (irq && mtvec_mode) ? ({mtvec_base, 2'b00} + {26'd0, irq_code, 2'b00})
                                               : {mtvec_base, 2'b00};

    // Trap entry outranks MRET, which outranks an ordinary CSR write
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            st_mie     <= 1'b0;
            st_mpie    <= 1'b0;
            mie_en     <= 3'd0;
            mtvec_base <= MTVEC_RST[31:2];
            mtvec_mode <= 1'b0;
            mscratch   <= 32'd0;
            mepc_w     <= 30'd0;
            mcause     <= 32'd0;
            mtval      <= 32'd0;
        end else if (trap) begin
            mepc_w  <= bus.i_pc[31:2];
            mcause  <= trap_cause;
            mtval   <= exc_tval;
            st_mpie <= st_mie;
            st_mie  <= 1'b0;
        end else if (is_mret) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
        end else if (wr_en) begin
            case (addr)
                A_MSTATUS:  begin st_mie <= wr_dat[3]; st_mpie <= wr_dat[7]; end
                A_MIE:      mie_en <= {wr_dat[11], wr_dat[7], wr_dat[3]};
                A_MTVEC:    begin mtvec_base <= wr_dat[31:2]; mtvec_mode <= VECTORED ? wr_dat[0] : 1'b0; end
                A_MSCRATCH: mscratch <= wr_dat;
                A_MEPC:     mepc_w <= wr_dat[31:2];
                A_MCAUSE:   mcause <= wr_dat;
                A_MTVAL:    mtval <= wr_dat;
                default:    ;
            endcase
        end
    end

    // Free-running counters; a software write to either half replaces that half and skips the tick
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            mcycle   <= 64'd0;
            minstret <= 64'd0;
        end else if (CNT_EN) begin
            if (wr_en && (addr == A_MCYCLE))        mcycle[31:0]  <= wr_dat;
            else if (wr_en && (addr == A_MCYCLEH))  mcycle[63:32] <= wr_dat;
            else                                    mcycle        <= mcycle + 64'd1;

            if (wr_en && (addr == A_MINSTRET))       minstret[31:0]  <= wr_dat;
            else if (wr_en && (addr == A_MINSTRETH)) minstret[63:32] <= wr_dat;
            else if (bus.i_retire && !trap)          minstret        <= minstret + 64'd1;
        end
    end
endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: architectural model compared every cycle plus literal spot checks.
// Latency: model predicts combinational outputs, then advances its state at each falling edge.
// Backpressure: not applicable; one request per cycle.
module tb_csr_unit;
    logic clk, rst;
    csr_unit_if bus();

    csr_unit #(.HART_ID(32'h0), .VECTORED(1'b1), .CNT_EN(1'b1), .MTVEC_RST(32'h0)) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus)
    );

    localparam bit [2:0] F_RW = 3'b001, F_RS = 3'b010, F_RC = 3'b011, F_RWI = 3'b101, F_RSI = 3'b110;

    int checks = 0;
    int failures = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- architectural model ----------------
    bit [31:0] m_csr [bit [11:0]];
    bit [63:0] m_cyc, m_ins;
    bit        e_trap, e_eret, e_ill, e_csr, e_wr;
    bit [31:0] e_rd, e_cause, e_tvec, e_tval, e_wval;
    bit [11:0] e_addr;

    function automatic void m_reset();
        m_csr.delete();
        m_csr[12'h300] = 32'h0000_1800;
        m_csr[12'h304] = 32'h0;
        m_csr[12'h305] = 32'h0;
        m_csr[12'h340] = 32'h0;
        m_csr[12'h341] = 32'h0;
        m_csr[12'h342] = 32'h0;
        m_csr[12'h343] = 32'h0;
        m_cyc = 64'd0;
        m_ins = 64'd0;
    endfunction

    function automatic bit [31:0] m_mip();
        bit [31:0] v = 32'h0;
        if (bus.i_irq_ext   === 1'b1) v = v + 32'h800;
        if (bus.i_irq_timer === 1'b1) v = v + 32'h080;
        if (bus.i_irq_sw    === 1'b1) v = v + 32'h008;
        return v;
    endfunction

    function automatic bit [31:0] m_read(input bit [11:0] a, output bit impl, output bit ro);
        impl = 1'b1;
        ro   = 1'b0;
        case (a)
            12'hF14: begin ro = 1'b1; return 32'h0; end
            12'h301: begin ro = 1'b1; return 32'h4000_0100; end
            12'h344: begin ro = 1'b1; return m_mip(); end
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            12'hB02: return m_ins[31:0];
            12'hB82: return m_ins[63:32];
            default: begin
                if (m_csr.exists(a)) return m_csr[a];
                impl = 1'b0;
                return 32'h0;
            end
        endcase
    endfunction

    function automatic bit [31:0] m_wmask(input bit [11:0] a);
        case (a)
            12'h300: return 32'h0000_0088;
            12'h304: return 32'h0000_0888;
            12'h305: return 32'hFFFF_FFFD;
            12'h341: return 32'hFFFF_FFFC;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic void m_write(input bit [11:0] a, input bit [31:0] v);
        bit [31:0] mk;
        case (a)
            12'hB00: m_cyc[31:0]  = v;
            12'hB80: m_cyc[63:32] = v;
            12'hB02: m_ins[31:0]  = v;
            12'hB82: m_ins[63:32] = v;
            default: begin
                mk = m_wmask(a);
                m_csr[a] = (m_csr[a] & ~mk) | (v & mk);
            end
        endcase
    endfunction

    task automatic m_eval();
        bit [31:0] in = bus.i_inst;
        bit [2:0]  f3 = in[14:12];
        bit        sys = (bus.i_csr_en === 1'b1) && (in[6:0] == 7'h73);
        bit        priv = sys && (f3 == 3'd0) && (in[19:7] == 13'd0);
        bit        mret = priv && (in[31:20] == 12'h302);
        bit        impl, ro, wreq;
        bit        fl [6];
        int        cd [6];
        bit [31:0] tv [6];
        int        ib [3];
        bit [31:0] src, st, pend, base;
        e_addr = in[31:20];
        e_csr  = sys && (f3[1:0] != 2'd0);
        e_rd   = m_read(e_addr, impl, ro);
        src    = f3[2] ? 32'(in[19:15]) : bus.i_wd;
        wreq   = e_csr && ((f3[1:0] == 2'd1) || (in[19:15] != 5'd0));
        e_ill  = e_csr && (!impl || (ro && wreq));
        case (f3[1:0])
            2'd1:    e_wval = src;
            2'd2:    e_wval = e_rd | src;
            default: e_wval = e_rd & ~src;
        endcase
        fl[0] = bus.i_ex_inst_addr;               cd[0] = 0;  tv[0] = bus.i_badaddr;
        fl[1] = bus.i_ex_ill;                     cd[1] = 2;  tv[1] = in;
        fl[2] = priv && (in[31:20] == 12'h001);   cd[2] = 3;  tv[2] = bus.i_pc;
        fl[3] = priv && (in[31:20] == 12'h000);   cd[3] = 11; tv[3] = 32'h0;
        fl[4] = bus.i_ex_ld_addr;                 cd[4] = 4;  tv[4] = bus.i_badaddr;
        fl[5] = bus.i_ex_st_addr;                 cd[5] = 6;  tv[5] = bus.i_badaddr;
        base   = m_csr[12'h305] & 32'hFFFF_FFFC;
        e_trap = 1'b0;
        e_cause = 32'h0;
        e_tval = 32'h0;
        e_tvec = base;
        for (int i = 0; i < 6; i++) begin
            if (fl[i] && !e_trap) begin
                e_trap = 1'b1; e_cause = 32'(cd[i]); e_tval = tv[i];
            end
        end
        st   = m_csr[12'h300];
        pend = m_csr[12'h304] & m_mip();
        ib[0] = 11; ib[1] = 3; ib[2] = 7;
        if (!e_trap && st[3]) begin
            for (int i = 0; i < 3; i++) begin
                if (!e_trap && pend[ib[i]]) begin
                    e_trap  = 1'b1;
                    e_cause = 32'h8000_0000 | 32'(ib[i]);
                    e_tval  = 32'h0;
                    if (m_csr[12'h305][0]) e_tvec = base + 32'(4 * ib[i]);
                end
            end
        end
        e_eret = mret && !e_trap;
        e_wr   = wreq && !e_ill && !e_trap;
    endtask

    task automatic m_step();
        bit [31:0] st = m_csr[12'h300];
        bit cw = e_wr && (e_addr == 12'hB00 || e_addr == 12'hB80);
        bit iw = e_wr && (e_addr == 12'hB02 || e_addr == 12'hB82);
        if (e_trap) begin
            m_csr[12'h341] = bus.i_pc & 32'hFFFF_FFFC;
            m_csr[12'h342] = e_cause;
            m_csr[12'h343] = e_tval;
            st[7] = st[3]; st[3] = 1'b0;
            m_csr[12'h300] = st;
        end else if (e_eret) begin
            st[3] = st[7]; st[7] = 1'b1;
            m_csr[12'h300] = st;
        end else if (e_wr) begin
            m_write(e_addr, e_wval);
        end
        if (!cw) m_cyc = m_cyc + 64'd1;
        if (!iw && bus.i_retire && !e_trap) m_ins = m_ins + 64'd1;
    endtask

    // One compare per falling edge, then the model advances as the DUT will at the next rise
    always @(negedge clk) begin
        if (!rst) m_reset();
        m_eval();
        chk("cmp_trap", 32'(bus.o_trap), 32'(e_trap));
        chk("cmp_eret", 32'(bus.o_eret), 32'(e_eret));
        chk("cmp_csr_ill", 32'(bus.o_csr_ill), 32'(e_ill));
        if (e_csr)  chk("cmp_rd", bus.o_rd, e_rd);
        if (e_trap) begin
            chk("cmp_tvec", bus.o_tvec, e_tvec);
            chk("cmp_cause", bus.o_cause, e_cause);
        end
        if (e_eret) chk("cmp_epc", bus.o_epc, m_csr[12'h341]);
        if (rst) m_step();
    end

    // ---------------- stimulus ----------------
    task automatic clr();
        bus.i_csr_en = 1'b0;       bus.i_inst = 32'h0;        bus.i_wd = 32'h0;
        bus.i_pc = 32'h1000;       bus.i_badaddr = 32'h0;     bus.i_retire = 1'b0;
        bus.i_ex_ill = 1'b0;       bus.i_ex_inst_addr = 1'b0;
        bus.i_ex_ld_addr = 1'b0;   bus.i_ex_st_addr = 1'b0;
        bus.i_irq_sw = 1'b0;       bus.i_irq_timer = 1'b0;    bus.i_irq_ext = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr(input bit [2:0] f3, input bit [11:0] a, input bit [4:0] s, input bit [31:0] wd);
        clr();
        bus.i_csr_en = 1'b1;
        bus.i_inst   = {a, s, f3, 5'd1, 7'h73};
        bus.i_wd     = wd;
        #1;
    endtask

    task automatic rd(input bit [11:0] a);
        csr(F_RS, a, 5'd0, 32'h0);
    endtask

    task automatic sys(input bit [31:0] inst, input bit [31:0] pc);
        clr();
        bus.i_csr_en = 1'b1;
        bus.i_inst   = inst;
        bus.i_pc     = pc;
    endtask

    initial begin
        rst = 1'b0;
        clr();
        #1;
        chk("rst_trap", 32'(bus.o_trap), 32'h0);
        chk("rst_eret", 32'(bus.o_eret), 32'h0);
        chk("rst_ill",  32'(bus.o_csr_ill), 32'h0);
        tick();
        rd(12'h305); chk("rst_mtvec", bus.o_rd, 32'h0); tick();
        rd(12'h300); chk("rst_mstatus", bus.o_rd, 32'h1800); tick();
        rst = 1'b1;
        rd(12'h301); chk("misa", bus.o_rd, 32'h4000_0100); tick();

        // reset mid-count
        csr(F_RW, 12'hB00, 5'd1, 32'd100); tick();
        rd(12'hB00); chk("mcycle_100", bus.o_rd, 32'd100);
        rst = 1'b0; #1;
        chk("rst_mid_mcycle", bus.o_rd, 32'd0);
        tick();
        rst = 1'b1;

        // ecall with vectored mtvec goes to base
        csr(F_RW, 12'h305, 5'd1, 32'h101); tick();
        rd(12'h305); chk("mtvec_rb", bus.o_rd, 32'h101); tick();
        csr(F_RSI, 12'h300, 5'd8, 32'h0); tick();
        sys(32'h0000_0073, 32'h80); bus.i_retire = 1'b1; #1;
        chk("ecall_trap", 32'(bus.o_trap), 32'h1);
        chk("ecall_tvec", bus.o_tvec, 32'h100);
        chk("ecall_cause", bus.o_cause, 32'd11);
        tick();
        rd(12'h341); chk("ecall_mepc", bus.o_rd, 32'h80); tick();
        rd(12'h342); chk("ecall_mcause", bus.o_rd, 32'd11); tick();
        rd(12'h343); chk("ecall_mtval", bus.o_rd, 32'h0); tick();
        rd(12'h300); chk("ecall_mstatus", bus.o_rd, 32'h1880); tick();

        // interrupts
        csr(F_RW, 12'h304, 5'd1, 32'h880); tick();
        csr(F_RSI, 12'h300, 5'd8, 32'h0); tick();
        clr(); bus.i_irq_ext = 1'b1; bus.i_irq_timer = 1'b1; bus.i_pc = 32'h140; #1;
        chk("mei_cause", bus.o_cause, 32'h8000_000B);
        chk("mei_tvec", bus.o_tvec, 32'h12C);
        tick();
        rd(12'h344); bus.i_irq_ext = 1'b1; bus.i_irq_timer = 1'b1; #1;
        chk("irq_masked", 32'(bus.o_trap), 32'h0);
        chk("mip_rd", bus.o_rd, 32'h880);
        tick();
        rd(12'h342); chk("mei_mcause", bus.o_rd, 32'h8000_000B); tick();
        rd(12'h341); chk("mei_mepc", bus.o_rd, 32'h140); tick();
        csr(F_RW, 12'h304, 5'd1, 32'h888); tick();
        csr(F_RSI, 12'h300, 5'd8, 32'h0); tick();
        clr(); bus.i_irq_sw = 1'b1; bus.i_irq_timer = 1'b1; #1;
        chk("msi_cause", bus.o_cause, 32'h8000_0003);
        chk("msi_tvec", bus.o_tvec, 32'h10C);
        tick();

        // exception priority, write suppression
        csr(F_RW, 12'h340, 5'd1, 32'h55); tick();
        csr(F_RW, 12'h340, 5'd1, 32'hDEAD);
        bus.i_ex_ill = 1'b1; bus.i_ex_ld_addr = 1'b1; bus.i_badaddr = 32'h1002; bus.i_pc = 32'h200; #1;
        chk("ill_cause", bus.o_cause, 32'd2);
        chk("ill_tvec", bus.o_tvec, 32'h100);
        tick();
        rd(12'h343); chk("ill_mtval", bus.o_rd, 32'h3400_90F3); tick();
        rd(12'h340); chk("ill_no_write", bus.o_rd, 32'h55); tick();
        rd(12'h341); chk("ill_mepc", bus.o_rd, 32'h200); tick();
        clr(); bus.i_ex_ld_addr = 1'b1; bus.i_badaddr = 32'h1002; bus.i_pc = 32'h204; #1;
        chk("ld_cause", bus.o_cause, 32'd4); tick();
        rd(12'h343); chk("ld_mtval", bus.o_rd, 32'h1002); tick();
        sys(32'h0010_0073, 32'h300); #1;
        chk("ebreak_cause", bus.o_cause, 32'd3); tick();
        rd(12'h343); chk("ebreak_mtval", bus.o_rd, 32'h300); tick();
        clr(); bus.i_ex_inst_addr = 1'b1; bus.i_ex_st_addr = 1'b1; bus.i_badaddr = 32'h2001; bus.i_pc = 32'h208; #1;
        chk("iaddr_cause", bus.o_cause, 32'd0); tick();

        // MRET
        csr(F_RS, 12'h300, 5'd1, 32'h80); tick();
        sys(32'h3020_0073, 32'h400); #1;
        chk("mret_eret", 32'(bus.o_eret), 32'h1);
        chk("mret_epc", bus.o_epc, 32'h208);
        tick();
        rd(12'h300); chk("mret_mstatus", bus.o_rd, 32'h1888); tick();

        // mcycle carry and write-beats-tick
        csr(F_RW, 12'hB80, 5'd1, 32'd7); tick();
        csr(F_RW, 12'hB00, 5'd1, 32'hFFFF_FFFE); tick();
        rd(12'hB00); chk("mcycle_fffe", bus.o_rd, 32'hFFFF_FFFE); tick();
        rd(12'hB00); chk("mcycle_ffff", bus.o_rd, 32'hFFFF_FFFF); tick();
        rd(12'hB80); chk("mcycleh_carry", bus.o_rd, 32'd8); tick();
        csr(F_RWI, 12'hB00, 5'd5, 32'h0); tick();
        rd(12'hB00); chk("mcycle_wr5", bus.o_rd, 32'd5); tick();

        // minstret: retire ignored on a trapping cycle
        csr(F_RWI, 12'hB02, 5'd0, 32'h0); tick();
        clr(); bus.i_retire = 1'b1; #1; tick();
        clr(); bus.i_retire = 1'b1; #1; tick();
        clr(); bus.i_retire = 1'b1; bus.i_ex_ld_addr = 1'b1; #1; tick();
        clr(); bus.i_retire = 1'b1; #1; tick();
        rd(12'hB02); chk("minstret_3", bus.o_rd, 32'd3); tick();
        rd(12'hB82); chk("minstreth_0", bus.o_rd, 32'd0); tick();

        // illegal accesses
        csr(F_RW, 12'h301, 5'd1, 32'h123); chk("misa_wr_ill", 32'(bus.o_csr_ill), 32'h1); tick();
        rd(12'h301); chk("misa_kept", bus.o_rd, 32'h4000_0100); tick();
        csr(F_RW, 12'h7FF, 5'd1, 32'h5);
        chk("unimpl_ill", 32'(bus.o_csr_ill), 32'h1);
        chk("unimpl_rd", bus.o_rd, 32'h0);
        tick();
        rd(12'hF14); chk("hartid_rd_ok", 32'(bus.o_csr_ill), 32'h0); tick();
        csr(F_RS, 12'hF14, 5'd1, 32'h1); chk("hartid_set_ill", 32'(bus.o_csr_ill), 32'h1); tick();
        csr(F_RC, 12'h340, 5'd0, 32'hFFFF_FFFF); tick();
        rd(12'h340); chk("rc_x0_nowrite", bus.o_rd, 32'h55); tick();

        clr();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
